reg_file32: RTL
===============

// Module: reg_file32
// PURPOSE
//  32 x 32-bit CPU register file: two combinational read ports, one clocked write port.
//  Built from 31 enable/clear 32-bit registers; x0 is hard-wired to zero.
//  Sits between the write-back stage, which drives We/Wn/D, and the decode/operand
//  stage, which reads Qa/Qb.
//  Internal write-through bypass: an operand read in the same cycle as its write
//  returns the new value.
// PARAMETERS
//  DW     32  data width of each register
//  AW     5   register address width; depth = 2**AW
//  BYPASS 1   1: same-cycle write-to-read forwarding; 0: read returns stored value
// PORTS
//  Clk  in   1   clock, rising edge
//  Clr  in   1   asynchronous, active-high reset; clears every register
//  We   in   1   write enable
//  Wn   in   AW  write register number
//  D    in   DW  write data
//  Rna  in   AW  read port A register number
//  Rnb  in   AW  read port B register number
//  Qa   out  DW  read port A data (combinational)
//  Qb   out  DW  read port B data (combinational)
// BEHAVIOUR
//  - Reset: Clk, single clock domain; Clr asynchronous active-high.
//    Clr=1 forces all registers r1..r31 to 0 immediately, without waiting for Clk.
//    Qa and Qb read 0 while Clr is high.
//    Clr dominates We: a write coincident with Clr, or with Clr release on the same
//    edge, is dropped.
//  - Write: on posedge Clk, if We=1 and Wn!=0, reg[Wn] <= D. Latency is 1 cycle to
//    storage. Writes to Wn=0 are discarded.
//  - Read: Qx = (Rnx==0) ? 0 : reg[Rnx]. Purely combinational, 0-cycle latency, no
//    clock involvement.
//  - Bypass (BYPASS=1): if We=1, Wn!=0, Wn==Rnx and Clr=0, then Qx = D in the same
//    cycle. Applies independently per port; both ports may bypass at once.
//  - BYPASS=0: a read of Wn during the write cycle returns the old value; the new
//    value is visible after the edge.
//  - Enables: one-hot decode of Wn gated by We gives per-register enables. At most
//    one register is written per edge.
//  - Hold: registers hold their value whenever We=0 or the register is not selected.
//  - Read addresses are fully decoded; every Rn value 0..31 is legal. There are no
//    X-producing paths after reset.
//  - Clr applied mid-operation: contents are lost and no partial write survives.
//    First valid write is on the first posedge with Clr=0.
// STRUCTURE
//  - Shared package rf_pkg: REG_DW=32, REG_AW=5, REG_ZERO=5'd0, typedef
//    logic [REG_DW-1:0] word_t. These are reused by the decode and write-back stages.
//  - Sub-module dffe32_clr: DW-bit register with enable and async active-high clear.
//    Instantiated for r1..r31 in a generate loop; r0 is a constant 0, not a register.
//  - In this file: 5-to-32 write decoder, two 32:1 read muxes, bypass compare logic.
// TESTING
//  1. Clr=1 pulse mid-cycle after filling r1..r31
//     -> Qa=Qb=0 for every Rn while Clr=1, before the next edge.
//     -> All registers still read 0 after Clr drops.
//  2. We=1, Wn=5, D=32'h0F0F0F0F, edge; then Rna=5, Rnb=5
//     -> Qa=Qb=32'h0F0F0F0F.
//     -> r4 and r6 still read 0.
//  3. We=1, Wn=0, D=32'hFFFFFFFF, edge; Rna=0 -> Qa=0.
//     -> Bypass not taken for Rn=0.
//  4. BYPASS=1, r7=32'h33333333; same cycle We=1, Wn=7, D=32'hCCCCCCCC, Rna=7, Rnb=7
//     -> Qa=Qb=32'hCCCCCCCC before the edge.
//     -> With BYPASS=0: 32'h33333333 before the edge, 32'hCCCCCCCC after it.
//  5. We=0, Wn=9, D=32'hDEADBEEF for 3 edges -> r9 unchanged (0).
//     Then We=1 for 1 edge -> r9=32'hDEADBEEF.
//  6. Write all r1..r31 with D=Wn*32'h01010101
//     -> Random dual-port reads match a scoreboard.
//     -> Back-to-back writes to the same Wn: last write wins.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file types and constants, also used by the decode and
// write-back stages.
package rf_pkg;

  localparam int REG_DW = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_DW-1:0] word_t;

endpackage : rf_pkg

// File: rtl/reg_file32_dffe32_clr.sv
// DW-bit storage register with load enable and asynchronous active-high clear.
module dffe32_clr
  import rf_pkg::*;
#(
  parameter int DW = REG_DW
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] q_q;
  logic [DW-1:0] q_d;

  // Load on enable, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = d_i;
    end else begin
      q_d = q_q;
    end
  end

  // Storage; clear wins over any load on the same edge.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : dffe32_clr

// File: rtl/reg_file32.sv
// 32 x 32-bit register file: two combinational read ports, one clocked write
// port, x0 hard-wired to zero, optional same-cycle write-through forwarding.
module reg_file32
  import rf_pkg::*;
#(
  parameter int DW     = REG_DW,
  parameter int AW     = REG_AW,
  parameter int BYPASS = 1
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic          We,
  input  logic [AW-1:0] Wn,
  input  logic [DW-1:0] D,
  input  logic [AW-1:0] Rna,
  input  logic [AW-1:0] Rnb,
  output logic [DW-1:0] Qa,
  output logic [DW-1:0] Qb
);

  localparam int DEPTH = 2 ** AW;

  logic                      wr_s;
  logic [DEPTH-1:1]          en_s;
  logic [DEPTH-1:0][DW-1:0]  regs_s;

  // A write to x0 is a no-op, so it must neither load nor forward.
  assign wr_s      = We && (Wn != AW'(REG_ZERO));
  assign regs_s[0] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    assign en_s[i] = wr_s && (Wn == AW'(i));

    dffe32_clr #(
      .DW (DW)
    ) u_reg (
      .clk_i (Clk),
      .clr_i (Clr),
      .en_i  (en_s[i]),
      .d_i   (D),
      .q_o   (regs_s[i])
    );
  end

  // Port A read mux with forwarding of the in-flight write.
  always_comb begin
    Qa = '0;
    if (Clr) begin
      Qa = '0;
    end else if ((BYPASS != 0) && wr_s && (Wn == Rna)) begin
      Qa = D;
    end else begin
      Qa = regs_s[Rna];
    end
  end

  // Port B read mux, independent of port A.
  always_comb begin
    Qb = '0;
    if (Clr) begin
      Qb = '0;
    end else if ((BYPASS != 0) && wr_s && (Wn == Rnb)) begin
      Qb = D;
    end else begin
      Qb = regs_s[Rnb];
    end
  end

endmodule : reg_file32
